sdf_axi_lite_master: RTL

AXI4-Lite initiator that drives the SDF NTT/INTT accelerator's AXI-Lite register slave. Holds a local 16-word input buffer and a 16-word result buffer. On a start pulse it:
- writes the 16 coefficients to the slave;
- issues the control set/clear write pair;
- polls the status register until done;
- reads the 16 results back.

It sits between a local controller (or processor-side glue) and the SDF wrapper, replacing bus-functional-model sequencing with synthesizable hardware.

---
 rtl/sdf_axi_lite_if.sv | 32 +++
 rtl/sdf_axi_lite_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_axi_lite_if.sv
// AXI4-Lite bus between the SDF job master and the accelerator register slave.
interface sdf_axi_lite_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/sdf_axi_lite_master.sv
// Sequences one SDF NTT/INTT job over AXI4-Lite: load 16 coefficients, pulse the
// control start bit, poll status until done, read back 16 results.
// Optional feature macro: SDF_MASTER_TIMEOUT_EN (bounds the status poll to
// POLL_TIMEOUT reads; on expiry err is set and the job finishes without readback).
module sdf_axi_lite_master #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  sdf_axi_lite_if.master        m_axi,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  in_we,
  input  logic [3:0]            in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [3:0]            out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned NUM_WORDS = 16;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned CTRL_ADDR = 16;
  localparam int unsigned STAT_ADDR = 17;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_COEF, S_WR_SET, S_WR_CLR, S_POLL, S_RD_RES, S_FIN
  } state_t;

  // Per-transaction phase: LAUNCH drives addr/data, ADDR waits for the address
  // (and write data) handshake, RESP waits for the response.
  typedef enum logic [1:0] {PH_LAUNCH, PH_ADDR, PH_RESP} phase_t;

  state_t                state_q, state_d;
  phase_t                phase_q, phase_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                  bready_c;
  logic                  aw_ok, w_ok, txn_done, resp_bad;

  logic [DATA_WIDTH-1:0] in_buf  [NUM_WORDS];
  logic [DATA_WIDTH-1:0] out_buf [NUM_WORDS];

`ifdef SDF_MASTER_TIMEOUT_EN
  localparam int unsigned PCNT_W = $clog2(POLL_TIMEOUT + 1);
  logic [PCNT_W-1:0] poll_cnt_q, poll_cnt_d;
`endif

  // A zero poll budget would make the timeout unreachable
  if (POLL_TIMEOUT == 0) begin : g_bad_cfg
    $error("POLL_TIMEOUT must be nonzero");
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_c;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign out_data      = out_buf[out_addr];

  // A channel is clear once its valid is low or is being accepted this cycle
  assign aw_ok = !awvalid_q || m_axi.awready;
  assign w_ok  = !wvalid_q  || m_axi.wready;

  // Next-state, next-output and bready decode
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    err_d     = err_q;
    bready_c  = 1'b0;
    txn_done  = 1'b0;
    resp_bad  = 1'b0;
`ifdef SDF_MASTER_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = mode;
          err_d     = 1'b0;
          idx_d     = '0;
          awaddr_d  = '0;
          wdata_d   = in_buf[0];
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          phase_d   = PH_ADDR;
          state_d   = S_WR_COEF;
`ifdef SDF_MASTER_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end

      S_WR_COEF, S_WR_SET, S_WR_CLR: begin
        unique case (phase_q)
          PH_LAUNCH: begin
            if (state_q == S_WR_COEF) begin
              awaddr_d = ADDR_WIDTH'(idx_q);
              wdata_d  = in_buf[idx_q[3:0]];
            end else begin
              awaddr_d = ADDR_WIDTH'(CTRL_ADDR);
              wdata_d  = DATA_WIDTH'({mode_q, ~mode_q, state_q == S_WR_SET});
            end
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            phase_d   = PH_ADDR;
          end
          PH_ADDR: begin
            if (m_axi.awready) awvalid_d = 1'b0;
            if (m_axi.wready)  wvalid_d  = 1'b0;
            if (aw_ok && w_ok) begin
              bready_c = 1'b1;
              if (m_axi.bvalid) begin
                txn_done = 1'b1;
                resp_bad = |m_axi.bresp;
              end else begin
                phase_d = PH_RESP;
              end
            end
          end
          PH_RESP: begin
            bready_c = 1'b1;
            if (m_axi.bvalid) begin
              txn_done = 1'b1;
              resp_bad = |m_axi.bresp;
            end
          end
          default: phase_d = PH_LAUNCH;
        endcase

        if (txn_done) begin
          phase_d = PH_LAUNCH;
          if (resp_bad) err_d = 1'b1;
          if (state_q == S_WR_COEF) begin
            if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
              idx_d   = '0;
              state_d = S_WR_SET;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else if (state_q == S_WR_SET) begin
            state_d = S_WR_CLR;
          end else begin
            state_d = S_POLL;
          end
        end
      end

      S_POLL, S_RD_RES: begin
        unique case (phase_q)
          PH_LAUNCH: begin
            araddr_d  = (state_q == S_POLL) ? ADDR_WIDTH'(STAT_ADDR) : ADDR_WIDTH'(idx_q);
            arvalid_d = 1'b1;
            phase_d   = PH_ADDR;
          end
          PH_ADDR: begin
            if (m_axi.arready) begin
              arvalid_d = 1'b0;
              rready_d  = 1'b1;
              phase_d   = PH_RESP;
            end
          end
          PH_RESP: begin
            if (m_axi.rvalid) begin
              rready_d = 1'b0;
              txn_done = 1'b1;
              resp_bad = |m_axi.rresp;
            end
          end
          default: phase_d = PH_LAUNCH;
        endcase

        if (txn_done) begin
          phase_d = PH_LAUNCH;
          if (resp_bad) err_d = 1'b1;
          if (state_q == S_POLL) begin
            if (m_axi.rdata[0]) begin
              idx_d   = '0;
              state_d = S_RD_RES;
            end else begin
`ifdef SDF_MASTER_TIMEOUT_EN
              if (poll_cnt_q == PCNT_W'(POLL_TIMEOUT - 1)) begin
                err_d   = 1'b1;
                state_d = S_FIN;
              end else begin
                poll_cnt_d = poll_cnt_q + PCNT_W'(1);
              end
`endif
            end
          end else if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
            state_d = S_FIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = !(state_d inside {S_IDLE, S_FIN});
    done_d = (state_d == S_FIN);
  end

  // Control state and registered bus outputs
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_LAUNCH;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef SDF_MASTER_TIMEOUT_EN
      poll_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef SDF_MASTER_TIMEOUT_EN
      poll_cnt_q <= poll_cnt_d;
`endif
    end
  end

  // Input coefficient buffer; host writes are dropped while a job runs
  always_ff @(posedge m_axi_aclk) begin
    if (in_we && !busy_q) in_buf[in_addr] <= in_data;
  end

  // Result buffer captures each readback beat
  always_ff @(posedge m_axi_aclk) begin
    if (state_q == S_RD_RES && m_axi.rvalid && rready_q) out_buf[idx_q[3:0]] <= m_axi.rdata;
  end

endmodule
